// File: rtl/mem_access_ctrl.sv
// Drives load/store transactions from the EX/MEM bundle on a valid/ready data port and registers the MEM/WB bundle.
// Latency: ALU/bubble 1 cycle; memory ops 1 + request wait + response wait. Upstream stalls while a transaction is in flight.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [70:0] ex_mem_bundle_in,
  output logic        stall_out,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic        dmem_req_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_resp_valid,
  input  logic [31:0] dmem_rdata,
  output logic [37:0] mem_wb_bundle_out,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // Counter holds the number of completed WAIT cycles, so the limit is hit one short of TIMEOUT_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          hold_reg_write, hold_we;
  logic [4:0]    hold_rd;
  logic [31:0]   hold_addr, hold_wdata;
  logic [37:0]   wb_nxt;
  logic          mis_set, to_set, latch_en;

  logic        in_reg_write, in_mem_en;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;

  assign in_reg_write = ex_mem_bundle_in[70];
  assign in_mem_en    = ex_mem_bundle_in[69];
  assign in_addr      = ex_mem_bundle_in[68:37];
  assign in_wdata     = ex_mem_bundle_in[36:5];
  assign in_rd        = ex_mem_bundle_in[4:0];

  assign stall_out      = (state != IDLE);
  assign dmem_req_valid = (state == REQ);
  assign dmem_req_we    = hold_we;
  assign dmem_addr      = hold_addr;
  assign dmem_wdata     = hold_wdata;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wb_nxt    = mem_wb_bundle_out;
    mis_set   = 1'b0;
    to_set    = 1'b0;
    latch_en  = 1'b0;
    case (state)
      IDLE: begin
        if (in_mem_en) begin
          wb_nxt = '0;
          if (in_addr[1:0] != 2'b00) begin
            mis_set = 1'b1;
          end else begin
            latch_en  = 1'b1;
            state_nxt = REQ;
          end
        end else begin
          wb_nxt = {in_reg_write, in_rd, in_addr};
        end
      end
      REQ: begin
        if (dmem_req_ready) begin
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end
      end
      WAIT: begin
        cnt_nxt = cnt + CW'(1);
        // A response in the final allowed cycle beats the timeout.
        if (dmem_resp_valid) begin
          wb_nxt    = {hold_reg_write, hold_rd, hold_we ? 32'b0 : dmem_rdata};
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          wb_nxt    = {hold_reg_write, hold_rd, 32'b0};
          to_set    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      hold_reg_write    <= 1'b0;
      hold_we           <= 1'b0;
      hold_rd           <= '0;
      hold_addr         <= '0;
      hold_wdata        <= '0;
      mem_wb_bundle_out <= '0;
      misalign_err      <= 1'b0;
      timeout_err       <= 1'b0;
    end else begin
      state             <= state_nxt;
      cnt               <= cnt_nxt;
      mem_wb_bundle_out <= wb_nxt;
      if (mis_set) misalign_err <= 1'b1;
      if (to_set)  timeout_err  <= 1'b1;
      if (latch_en) begin
        hold_reg_write <= in_reg_write;
        hold_we        <= ~in_reg_write;
        hold_rd        <= in_rd;
        hold_addr      <= in_addr;
        hold_wdata     <= in_wdata;
      end
    end
  end

endmodule
